// File: rtl/people_move_control.sv
// Player-position controller: turns held direction keys into a rate-limited,
// bounds-clamped sprite position and raises a sticky goal flag.
module people_move_control #(
   parameter int ACTIVE_STAGE = 5,
   parameter int START_LEFT   = 200,
   parameter int START_UP     = 335,
   parameter int MIN_LEFT     = 40,
   parameter int MAX_LEFT     = 560,
   parameter int MIN_UP       = 40,
   parameter int MAX_UP       = 400,
   parameter int STEP         = 5,
   parameter int MOVE_DIV     = 4,
   parameter int GOAL_LEFT    = 500,
   parameter int GOAL_UP      = 60,
   parameter int GOAL_SIZE    = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] stage_state,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       fail,
   output logic [9:0] people_up,
   output logic [9:0] people_left,
   output logic [1:0] facing,
   output logic       moving,
   output logic       goal
);

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int DIV_W = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

   // Bounds are pre-offset by STEP so the checks never need wrapping arithmetic.
   localparam logic [9:0] UP_LO   = 10'(MIN_UP + STEP);
   localparam logic [9:0] UP_HI   = 10'(MAX_UP - STEP);
   localparam logic [9:0] LEFT_LO = 10'(MIN_LEFT + STEP);
   localparam logic [9:0] LEFT_HI = 10'(MAX_LEFT - STEP);
   localparam logic [9:0] STEP_V  = 10'(STEP);

   localparam logic [10:0] GX_LO = 11'(GOAL_LEFT);
   localparam logic [10:0] GX_HI = 11'(GOAL_LEFT + GOAL_SIZE - 1);
   localparam logic [10:0] GY_LO = 11'(GOAL_UP);
   localparam logic [10:0] GY_HI = 11'(GOAL_UP + GOAL_SIZE - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             in_stage;
   logic             active;
   logic             key_any;
   dir_t             win_dir;
   logic             move_ok;
   logic [9:0]       next_up;
   logic [9:0]       next_left;
   logic [10:0]      centre_x;
   logic [10:0]      centre_y;
   logic             goal_hit;

   assign in_stage = (stage_state == 3'(ACTIVE_STAGE));
   assign active   = in_stage && !fail && !goal;
   assign key_any  = key_up || key_down || key_left || key_right;

   assign centre_x = {1'b0, people_left} + 11'd19;
   assign centre_y = {1'b0, people_up} + 11'd19;
   assign goal_hit = (centre_x >= GX_LO) && (centre_x <= GX_HI) &&
                     (centre_y >= GY_LO) && (centre_y <= GY_HI);

   // Fixed-priority key arbitration and the bounds check for the winner.
   always_comb begin
      win_dir   = DIR_RIGHT;
      move_ok   = 1'b0;
      next_up   = people_up;
      next_left = people_left;
      if (key_up) begin
         win_dir = DIR_UP;
      end else if (key_down) begin
         win_dir = DIR_DOWN;
      end else if (key_left) begin
         win_dir = DIR_LEFT;
      end
      case (win_dir)
         DIR_UP: begin
            move_ok = (people_up >= UP_LO);
            next_up = people_up - STEP_V;
         end
         DIR_DOWN: begin
            move_ok = (people_up <= UP_HI);
            next_up = people_up + STEP_V;
         end
         DIR_LEFT: begin
            move_ok   = (people_left >= LEFT_LO);
            next_left = people_left - STEP_V;
         end
         default: begin
            move_ok   = (people_left <= LEFT_HI);
            next_left = people_left + STEP_V;
         end
      endcase
   end

   // Outside the active stage the player is held at spawn; inside it, a step
   // opportunity comes every MOVE_DIV active cycles and fail/goal freeze everything.
   always_ff @(posedge clk) begin
      if (rst || !in_stage) begin
         people_left <= 10'(START_LEFT);
         people_up   <= 10'(START_UP);
         facing      <= DIR_RIGHT;
         moving      <= 1'b0;
         goal        <= 1'b0;
         div_cnt     <= '0;
      end else begin
         moving <= 1'b0;
         if (goal_hit) begin
            goal <= 1'b1;
         end
         if (active) begin
            if (div_cnt != DIV_LAST) begin
               div_cnt <= div_cnt + DIV_W'(1);
            end else begin
               div_cnt <= '0;
               if (key_any) begin
                  facing <= win_dir;
                  if (move_ok) begin
                     people_up   <= next_up;
                     people_left <= next_left;
                     moving      <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule
